effect_frame_dispatcher: RTL and testbench
==========================================

Name: effect_frame_dispatcher

Overview:
- Initiator side of the effect START/DONE frame handshake.
- Accepts signed 16-bit samples from the codec receive path and buffers them in a small FIFO.
- Issues one START pulse per sample to an effect core (e.g. overdrive_effect) and captures output_frame on DONE.
- Presents the processed sample to the codec transmit path with a valid/ready handshake. Provides bypass, a DONE timeout and sticky error flags.

Parameters:
- DATA_W, 16, sample width (signed two's complement)
- FIFO_DEPTH, 4, input sample buffer entries (power of two, >=2)
- TIMEOUT_CYCLES, 1024, maximum CLK cycles spent in WAIT before abandoning a frame

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- sample_valid  in  1  input sample present this cycle
- sample_in  in  DATA_W  signed input sample
- sample_ready  out  1  FIFO not full
- gain_sel  in  1  gain setting, latched per frame at dispatch
- bypass  in  1  route dry sample straight to output, latched per frame at dispatch
- START  out  1  one-cycle frame start to effect
- input_frame  out  DATA_W  sample to effect, held stable from START until the frame ends
- gain  out  1  gain to effect, held stable with input_frame
- DONE  in  1  effect result valid
- output_frame  in  DATA_W  effect result
- out_valid  out  1  processed sample available
- out_sample  out  DATA_W  processed sample
- out_ready  in  1  downstream accepts out_sample
- overflow  out  1  sticky: a sample was dropped because the FIFO was full
- timeout_err  out  1  sticky: DONE did not arrive within TIMEOUT_CYCLES

Behaviour:
- CLK is the only clock. RESET is synchronous and active-high.
- Reset state:
  - START, input_frame, gain, out_valid, out_sample, overflow and timeout_err are all 0.
  - FIFO is empty, so sample_ready = 1.
  - FSM is in IDLE and the timeout counter is 0.
- FIFO write:
  - A write occurs when sample_valid && sample_ready.
  - If sample_valid while full, the sample is dropped and overflow is set.
  - A pop in the same cycle does not rescue the write; sample_ready is !full from the registered count.
- FIFO read:
  - The FIFO is read only in IDLE.
  - Empty status is registered, so a write in cycle t is first visible to IDLE in cycle t+1.
- FSM states: IDLE, ISSUE, WAIT, OUTPUT.
  - IDLE: if FIFO not empty, pop the head into input_frame and latch gain<=gain_sel and bypass. If bypass=1, load out_sample<=head and go to OUTPUT; otherwise go to ISSUE.
  - ISSUE: START=1 for exactly this cycle. DONE is ignored in this cycle. Clear the counter and go to WAIT.
  - WAIT: on DONE, out_sample<=output_frame and go to OUTPUT. If the counter reaches TIMEOUT_CYCLES-1 without DONE, out_sample<=input_frame (dry), set timeout_err and go to OUTPUT. DONE has priority over timeout when both occur in the same cycle.
  - OUTPUT: out_valid=1 and out_sample is held until out_ready. On the handshake cycle, go to IDLE with out_valid=0 the next cycle. The next dispatch takes one IDLE cycle, so there is no back-to-back pop in the handshake cycle.
- Latency, with the write in cycle t:
  - Effect path: pop at t+1, START at t+2. DONE at cycle d (d>=t+3) gives out_valid at d+1.
  - Bypass path: out_valid at t+2.
- DONE arriving outside WAIT (IDLE, ISSUE, OUTPUT, or after a timeout) is ignored.
- Changes to bypass or gain_sel mid-frame have no effect until the next dispatch.
- Arithmetic: none. Samples pass through bit-exact; no saturation or resizing.
- Reset mid-frame abandons the frame: START never re-pulses, the FIFO contents are lost, and a late DONE is ignored.
- Sticky flags clear only on RESET.

Decomposition:
- Package pedal_pkg holds:
  - sample_t = logic signed [15:0]
  - dispatch_state_t enum {IDLE, ISSUE, WAIT, OUTPUT}
  - default TIMEOUT_CYCLES constant
- One sub-module, sample_fifo: a synchronous FIFO with parameters DEPTH and DATA_W, ports push/pop/din/dout/full/empty, and a registered count. The FSM, timeout counter and output register stay in effect_frame_dispatcher.

Test Plan:
- Basic frame: write 16'h3333 with gain_sel=0 and have the model respond 3 cycles after START with output_frame=16'h6666. Expect START high exactly 1 cycle, input_frame=16'h3333 and gain=0 stable until DONE, and out_sample=16'h6666 with out_valid one cycle after DONE.
- Bypass: with bypass=1, write 16'h7530. Expect no START, and out_sample=16'h7530 with out_valid at t+2.
- Overflow: with out_ready=0 and the model stalled, write 7 samples (16'h0001..16'h0007). Expect:
  - one popped into the held frame;
  - FIFO fills with 4;
  - the remaining 2 dropped, overflow=1 and sample_ready=0;
  - after releasing, outputs appear in order 0001..0005.
- Timeout: the model never asserts DONE for 16'h1234. Expect out_sample=16'h1234 exactly TIMEOUT_CYCLES cycles after entering WAIT and timeout_err=1. A late DONE produces no second out_valid.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Expect out_sample stable, no new START, then resumption after the handshake.
- Reset mid-WAIT: assert RESET for 1 cycle during WAIT, then pulse DONE. Expect all outputs 0, out_valid stays 0 and sample_ready=1.

Source files
------------

// File: rtl/pedal_pkg.sv
// rtl/pedal_pkg.sv - shared sample type, dispatcher states and default timeout
package pedal_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUTPUT
  } dispatch_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous power-of-two sample FIFO with registered occupancy count
module sample_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [AW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: contents are only observable through the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/effect_frame_dispatcher.sv
// rtl/effect_frame_dispatcher.sv - buffers codec samples and runs one START/DONE frame per sample
module effect_frame_dispatcher
  import pedal_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              sample_ready,
  input  logic              gain_sel,
  input  logic              bypass,
  output logic              START,
  output logic [DATA_W-1:0] input_frame,
  output logic              gain,
  input  logic              DONE,
  input  logic [DATA_W-1:0] output_frame,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sample,
  input  logic              out_ready,
  output logic              overflow,
  output logic              timeout_err
);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dispatch_state_t   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic              gain_q, gain_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ovf_q, ovf_d;
  logic              tmo_q, tmo_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  assign fifo_push    = sample_valid && !fifo_full;
  assign sample_ready = !fifo_full;

  sample_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sample_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      gain_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      gain_q  <= gain_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    gain_d    = gain_q;
    out_d     = out_q;
    tmo_d     = tmo_q;
    ovf_d     = ovf_q | (sample_valid & fifo_full);
    fifo_pop  = 1'b0;
    START     = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          frame_d  = fifo_dout;
          gain_d   = gain_sel;
          if (bypass) begin
            out_d   = fifo_dout;
            state_d = OUTPUT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        START   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // DONE wins over an expiring timeout in the same cycle.
        if (DONE) begin
          out_d   = output_frame;
          state_d = OUTPUT;
        end else if (cnt_q == CNT_LAST) begin
          out_d   = frame_q;
          tmo_d   = 1'b1;
          state_d = OUTPUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign input_frame = frame_q;
  assign gain        = gain_q;
  assign out_sample  = out_q;
  assign overflow    = ovf_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_effect_frame_dispatcher.sv
// tb/tb_effect_frame_dispatcher.sv - self-checking bench with a behavioural effect core and output scoreboard
module tb_effect_frame_dispatcher;
  localparam int TO = 64;

  logic        CLK;
  logic        RESET;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic        sample_ready;
  logic        gain_sel;
  logic        bypass;
  logic        START;
  logic [15:0] input_frame;
  logic        gain;
  logic        DONE;
  logic [15:0] output_frame;
  logic        out_valid;
  logic [15:0] out_sample;
  logic        out_ready;
  logic        overflow;
  logic        timeout_err;

  effect_frame_dispatcher #(
    .DATA_W         (16),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sample_ready (sample_ready),
    .gain_sel     (gain_sel),
    .bypass       (bypass),
    .START        (START),
    .input_frame  (input_frame),
    .gain         (gain),
    .DONE         (DONE),
    .output_frame (output_frame),
    .out_valid    (out_valid),
    .out_sample   (out_sample),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .timeout_err  (timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Effect core model controls: 0 random delay, 1 fixed delay, 2 never answers
  int eff_mode   = 1;
  int eff_delay  = 3;
  int inject_req = 0;
  logic exp_gain = 1'b0;

  // Written only by the effect core model
  int n_start      = 0;
  int n_width_viol = 0;
  int n_gain_bad   = 0;

  function automatic logic [15:0] fx(input logic [15:0] x, input logic g);
    logic [15:0] two;
    two = x << 1;
    return g ? 16'(two + x) : two;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int done_cnt = 0;
    int inject_ack = 0;
    logic start_prev = 1'b0;
    logic [15:0] pending = '0;
    DONE = 1'b0;
    output_frame = '0;
    forever begin
      @(negedge CLK);
      DONE = 1'b0;
      if (inject_req != inject_ack) begin
        inject_ack   = inject_req;
        DONE         = 1'b1;
        output_frame = 16'hDEAD;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          DONE         = 1'b1;
          output_frame = pending;
        end
      end
      if (START) begin
        n_start++;
        if (start_prev) n_width_viol++;
        if (gain !== exp_gain) n_gain_bad++;
        pending = fx(input_frame, gain);
        if (eff_mode == 0)      done_cnt = $urandom_range(1, 8);
        else if (eff_mode == 1) done_cnt = eff_delay;
        else                    done_cnt = 0;
      end
      start_prev = START;
    end
  end

  task automatic check_zero_state(input string pfx);
    check({pfx, "_start"},  START,        0);
    check({pfx, "_iframe"}, input_frame,  0);
    check({pfx, "_gain"},   gain,         0);
    check({pfx, "_ovalid"}, out_valid,    0);
    check({pfx, "_osamp"},  out_sample,   0);
    check({pfx, "_ovf"},    overflow,     0);
    check({pfx, "_tmo"},    timeout_err,  0);
    check({pfx, "_ready"},  sample_ready, 1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    sample_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic write1(input logic [15:0] x);
    sample_valid = 1'b1;
    sample_in = x;
    tick();
    sample_valid = 1'b0;
  endtask

  // Gathers n output handshakes (out_ready driven by caller) and compares them in order.
  task automatic collect(input string tag, input logic [15:0] exp_q[$]);
    logic [15:0] got_q[$];
    for (int c = 0; c < 600 && got_q.size() < exp_q.size(); c++) begin
      if (out_valid && out_ready) got_q.push_back(out_sample);
      tick();
    end
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_data"}, got_q[i], exp_q[i]);
  endtask

  task automatic wait_out_valid(input string tag);
    int c;
    for (c = 0; c < 200 && !out_valid; c++) tick();
    check({tag, "_reached"}, out_valid, 1);
  endtask

  // Random traffic with fixed bypass/gain; a scoreboard of pushed samples predicts outputs.
  task automatic rand_seg(input string tag, input int n);
    logic [15:0] q[$];
    int outstanding = 0;
    logic push;
    logic [15:0] x;
    exp_gain = gain_sel;
    eff_mode = 0;
    for (int c = 0; c < n + 300; c++) begin
      push = (c < n) && (outstanding <= 3) && ($urandom_range(0, 1) == 1);
      x = 16'($urandom);
      sample_valid = push;
      sample_in = x;
      out_ready = (c >= n) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (push) begin
        check({tag, "_ready"}, sample_ready, 1);
        q.push_back(bypass ? x : fx(x, gain_sel));
        outstanding++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check({tag, "_spurious"}, out_valid, 0);
        end else begin
          check({tag, "_out"}, out_sample, q.pop_front());
          outstanding--;
        end
      end
      @(posedge CLK);
      #1;
      if (c >= n && outstanding == 0) break;
    end
    sample_valid = 1'b0;
    check({tag, "_drained"}, outstanding, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [15:0] eq[$];
    RESET = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    gain_sel = 1'b0;
    bypass = 1'b0;
    out_ready = 1'b0;
    do_reset();
    check_zero_state("rst");

    // Basic frame with mid-frame gain_sel/bypass changes that must not take effect
    exp_gain = 1'b0; eff_mode = 1; eff_delay = 3;
    write1(16'h3333);
    check("basic_nostart_pop", START, 0);
    tick();
    check("basic_start", START, 1);
    check("basic_iframe", input_frame, 16'h3333);
    check("basic_gain", gain, 0);
    gain_sel = 1'b1; bypass = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("basic_start_low", START, 0);
      check("basic_iframe_hold", input_frame, 16'h3333);
      check("basic_gain_hold", gain, 0);
      check("basic_ovalid_low", out_valid, 0);
    end
    tick();
    check("basic_ovalid", out_valid, 1);
    check("basic_osamp", out_sample, 16'h6666);
    gain_sel = 1'b0; bypass = 1'b0;
    out_ready = 1'b1;
    tick();
    check("basic_ovalid_drop", out_valid, 0);
    out_ready = 1'b0;

    // Bypass
    do_reset();
    bypass = 1'b1;
    n0 = n_start;
    write1(16'h7530);
    check("byp_t1_ovalid", out_valid, 0);
    tick();
    check("byp_t2_ovalid", out_valid, 1);
    check("byp_osamp", out_sample, 16'h7530);
    check("byp_nostart", n_start, n0);
    out_ready = 1'b1;
    tick();
    bypass = 1'b0;
    out_ready = 1'b0;

    // Overflow: first sample held in a long frame, FIFO fills, two dropped
    do_reset();
    eff_mode = 1; eff_delay = 40; exp_gain = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if (i == 6) begin
        check("ovf_before", overflow, 0);
        check("ovf_full_ready", sample_ready, 0);
      end
      sample_valid = 1'b1;
      sample_in = 16'(i);
      tick();
    end
    sample_valid = 1'b0;
    check("ovf_flag", overflow, 1);
    check("ovf_ready", sample_ready, 0);
    eff_delay = 2;
    out_ready = 1'b1;
    eq = '{16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A};
    collect("ovf_order", eq);
    check("ovf_sticky", overflow, 1);
    check("ovf_no_tmo", timeout_err, 0);
    out_ready = 1'b0;

    // DONE on the final WAIT cycle beats the timeout
    do_reset();
    eff_mode = 1; eff_delay = TO;
    write1(16'h0101);
    for (int i = 0; i < TO + 1; i++) tick();
    check("edge_pre_ovalid", out_valid, 0);
    tick();
    check("edge_ovalid", out_valid, 1);
    check("edge_osamp", out_sample, fx(16'h0101, 1'b0));
    check("edge_no_tmo", timeout_err, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Timeout with late DONE
    do_reset();
    eff_mode = 2;
    write1(16'h1234);
    for (int i = 0; i < TO + 1; i++) tick();
    check("tmo_pre_ovalid", out_valid, 0);
    check("tmo_pre_flag", timeout_err, 0);
    tick();
    check("tmo_ovalid", out_valid, 1);
    check("tmo_osamp", out_sample, 16'h1234);
    check("tmo_flag", timeout_err, 1);
    inject_req++;
    tick();
    check("tmo_late_hold", out_sample, 16'h1234);
    out_ready = 1'b1;
    tick();
    check("tmo_hs_drop", out_valid, 0);
    n0 = n_start;
    inject_req++;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tmo_late_novalid", out_valid, 0);
    end
    check("tmo_late_nostart", n_start, n0);
    check("tmo_sticky", timeout_err, 1);
    out_ready = 1'b0;

    // Backpressure
    do_reset();
    eff_mode = 1; eff_delay = 2;
    write1(16'h0A0A);
    write1(16'h0B0B);
    wait_out_valid("bp");
    n0 = n_start;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_samp", out_sample, fx(16'h0A0A, 1'b0));
      tick();
    end
    check("bp_nostart", n_start, n0);
    out_ready = 1'b1;
    eq = '{fx(16'h0A0A, 1'b0), fx(16'h0B0B, 1'b0)};
    collect("bp_resume", eq);
    out_ready = 1'b0;

    // Reset during WAIT, then a stray DONE
    do_reset();
    eff_mode = 2;
    write1(16'h5A5A);
    tick();
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_zero_state("midrst");
    n0 = n_start;
    inject_req++;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_novalid", out_valid, 0);
      check("midrst_ready", sample_ready, 1);
    end
    check("midrst_nostart", n_start, n0);

    // Randomized segments
    do_reset();
    gain_sel = 1'b0; bypass = 1'b0;
    rand_seg("rnd_g0", 200);
    gain_sel = 1'b1;
    rand_seg("rnd_g1", 200);
    bypass = 1'b1;
    rand_seg("rnd_byp", 200);
    gain_sel = 1'b0; bypass = 1'b0;
    rand_seg("rnd_g0b", 200);

    check("start_one_cycle", n_width_viol, 0);
    check("start_gain_latched", n_gain_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
